regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the single-cycle CPU register file, for the pipelined core.
- Adds asynchronous clear, hard-wired x0, and a write-to-read bypass so writeback and decode can share a cycle.
- Adds a busy-bit scoreboard with issue/retire tracking, which produces decode-stage stall requests.
- Sits between the decode stage (read and issue ports) and the writeback stage (write port); exports a0 for the testbench and display.

Parameters:
- ADDR_WIDTH, 5, register index width; the file holds 2**ADDR_WIDTH registers.
- DATA_WIDTH, 32, register data width.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = read returns the stored value only.
- DBG_REG, 10, index of the register mirrored on a0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- A1  in  ADDR_WIDTH  read port 1 address (rs1).
- A2  in  ADDR_WIDTH  read port 2 address (rs2).
- A3  in  ADDR_WIDTH  write/retire address (rd from writeback).
- WE3  in  1  write enable; also retires the scoreboard entry for A3.
- WD3  in  DATA_WIDTH  write data.
- iss_valid  in  1  an instruction with a destination register is issuing this cycle.
- iss_rd  in  ADDR_WIDTH  destination of the issuing instruction.
- RD1  out  DATA_WIDTH  read data 1, combinational.
- RD2  out  DATA_WIDTH  read data 2, combinational.
- busy1  out  1  rs1 has an outstanding producer that is not resolved this cycle.
- busy2  out  1  rs2 has an outstanding producer that is not resolved this cycle.
- stall  out  1  busy1 OR busy2.
- pending_cnt  out  ADDR_WIDTH+1  number of registers currently marked busy (registered).
- a0  out  DATA_WIDTH  contents of register DBG_REG, combinational.

Behaviour:
- Reset (asynchronous, rst=1): all registers = 0, all busy bits = 0, pending_cnt = 0.
  - While rst=1: writes and issues are ignored and bypass is disabled.
  - Consequently RD1 = RD2 = a0 = 0, busy1 = busy2 = stall = 0.
  - Reset asserted mid-operation discards all pending state immediately; there is no drain.
- x0: reads always return 0, never busy. WE3 with A3=0 leaves all state unchanged. iss_valid with iss_rd=0 is ignored.
- Write: on a rising edge with WE3=1 and A3≠0, reg[A3] <= WD3.
- Read: RDn = 0 if An=0. Otherwise, if BYPASS=1, WE3=1 and A3=An, RDn = WD3. Otherwise RDn = reg[An]. Zero-latency, combinational.
- a0 follows the same rule applied to DBG_REG, including bypass.
- Scoreboard, next-state of busy[r] for r≠0:
  - set if iss_valid and iss_rd=r;
  - else clear if WE3 and A3=r;
  - else hold.
  - Issue and retire to the same register in the same cycle: set wins, because the new producer supersedes.
- busyn = busy[An] AND NOT (BYPASS AND WE3 AND A3=An); forced to 0 when An=0. With BYPASS=0, a register retiring this cycle still reports busy.
- stall = busy1 | busy2. It is driven only by state and same-cycle retire, never by iss_valid, which avoids a combinational loop through decode.
- pending_cnt:
  - +1 when the issue sets a bit that was 0;
  - −1 when the retire clears a bit that was 1 and no issue is targeting that register;
  - both events on different registers: net 0.
  - WAW re-issue to an already-busy register: no change. Retire of a non-busy register: no change.
  - Invariant: pending_cnt == popcount(busy) at every edge. The maximum is 2**ADDR_WIDTH−1, so the counter never wraps.

Decomposition:
- Package regfile_pkg:
  - typedef reg_addr_t, logic[ADDR_WIDTH-1:0] at the default width;
  - constants ZERO_REG=0 and A0_REG=10;
  - function onehot_dec, address to one-hot mask with bit 0 forced low.
- One sub-module, regfile_scoreboard. It holds the busy vector and pending_cnt and computes busy1/busy2. regfile_sb instantiates it beside the storage array and the bypass muxes.

Test Plan:
- Reset, then release with A1=10, A2=0 → RD1=0, RD2=0, a0=0, stall=0, pending_cnt=0. Write WE3=1, A3=0, WD3=0xDEADBEEF, then read A1=0 → RD1=0.
- Issue iss_rd=5; next cycle A1=5 → busy1=1, stall=1, pending_cnt=1. Then WE3=1, A3=5, WD3=0x1234 with BYPASS=1 → same cycle RD1=0x1234, busy1=0; next cycle pending_cnt=0, RD1=0x1234.
- BYPASS=0 build, same sequence → during the retire cycle RD1 = old value (0), busy1=1; next cycle RD1=0x1234, busy1=0.
- x7 busy; same cycle issue iss_rd=7 and retire A3=7 WD3=0x55 → busy[7] stays 1, pending_cnt unchanged at 1, reg[7]=0x55.
- Issue iss_rd=3 while retiring x9 (busy) → pending_cnt unchanged net. Issue x3 again (WAW) → pending_cnt unchanged. Retire x4 (not busy) → pending_cnt unchanged.
- Issue x1..x4 over 4 cycles (pending_cnt=4). Assert rst asynchronously between edges → immediately pending_cnt=0, stall=0, all reads 0. Write x10=0x2A after release → a0=0x2A in the same cycle via bypass and after the edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the pipelined-core register file.
//   reg_addr_t  : register index at the default 5-bit width
//   ZERO_REG    : hard-wired zero register index
//   A0_REG      : register mirrored on the debug/display output by default
//   onehot_dec  : register index to one-hot mask, bit 0 always low so x0
//                 can never be written or marked busy
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int MAX_ADDR_W = 8;
    localparam int MAX_REGS   = 2 ** MAX_ADDR_W;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam int ZERO_REG = 0;
    localparam int A0_REG   = 10;

    function automatic logic [MAX_REGS-1:0] onehot_dec(input int unsigned addr);
        logic [MAX_REGS-1:0] mask;
        mask = '0;
        if (addr < MAX_REGS) begin
            mask[addr] = 1'b1;
        end
        mask[ZERO_REG] = 1'b0;
        return mask;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register marking an outstanding producer.
//   clk, rst        : clock, asynchronous active-high clear
//   a1, a2          : decode read addresses (rs1, rs2)
//   a3, we3         : writeback address / retire strobe
//   iss_valid/iss_rd: issuing instruction and its destination
//   busy1, busy2    : rs1/rs2 still waiting on a producer this cycle
//   pending_cnt     : registered count of busy bits
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] a1,
    input  logic [ADDR_WIDTH-1:0] a2,
    input  logic [ADDR_WIDTH-1:0] a3,
    input  logic                  we3,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    output logic                  busy1,
    output logic                  busy2,
    output logic [ADDR_WIDTH:0]   pending_cnt
);

    localparam int NREG = 2 ** ADDR_WIDTH;
    localparam bit BYP  = (BYPASS != 0);
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    logic [NREG-1:0]     busy_q;
    logic [NREG-1:0]     busy_d;
    logic [NREG-1:0]     set_mask;
    logic [NREG-1:0]     clr_mask;
    logic [ADDR_WIDTH:0] cnt_q;
    logic [ADDR_WIDTH:0] cnt_d;
    logic                inc;
    logic                dec;

    // Issue beats retire on the same register: the new producer supersedes.
    // The count moves only when a bit actually flips, so it always equals
    // the popcount of busy_q.
    always_comb begin
        set_mask = iss_valid ? NREG'(onehot_dec(32'(iss_rd))) : '0;
        clr_mask = we3 ? NREG'(onehot_dec(32'(a3))) : '0;
        busy_d   = set_mask | (busy_q & ~clr_mask);
        inc      = |(set_mask & ~busy_q);
        dec      = |(clr_mask & busy_q & ~set_mask);
        cnt_d    = cnt_q;
        if (inc && !dec) begin
            cnt_d = cnt_q + (ADDR_WIDTH+1)'(1);
        end else if (dec && !inc) begin
            cnt_d = cnt_q - (ADDR_WIDTH+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // A retire in the same cycle resolves the hazard only when its data is
    // forwarded; without bypass the reader must wait for the stored value.
    assign busy1 = (a1 != ZERO_ADDR) && busy_q[a1] && !(BYP && we3 && (a3 == a1));
    assign busy2 = (a2 != ZERO_ADDR) && busy_q[a2] && !(BYP && we3 && (a3 == a2));

    assign pending_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with hard-wired x0, write-to-read bypass and a busy-bit
// scoreboard that produces decode-stage stall requests.
//   clk, rst        : clock, asynchronous active-high clear of all state
//   A1, A2 / RD1,RD2: combinational read ports
//   A3, WE3, WD3    : writeback port; WE3 also retires the A3 busy bit
//   iss_valid/iss_rd: issuing instruction marking its destination busy
//   busy1, busy2    : per-port hazard flags; stall = busy1 | busy2
//   pending_cnt     : number of busy registers (registered)
//   a0              : contents of DBG_REG, same read rule as RD1/RD2
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int BYPASS     = 1,
    parameter int DBG_REG    = A0_REG
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] A1,
    input  logic [ADDR_WIDTH-1:0] A2,
    input  logic [ADDR_WIDTH-1:0] A3,
    input  logic                  WE3,
    input  logic [DATA_WIDTH-1:0] WD3,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  stall,
    output logic [ADDR_WIDTH:0]   pending_cnt,
    output logic [DATA_WIDTH-1:0] a0
);

    localparam int NREG = 2 ** ADDR_WIDTH;
    localparam bit BYP  = (BYPASS != 0);
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);
    localparam logic [ADDR_WIDTH-1:0] DBG_ADDR  = ADDR_WIDTH'(DBG_REG);

    logic [DATA_WIDTH-1:0] mem [NREG];
    logic                  we_live;
    logic                  wr_en;
    logic                  iss_live;

    // Writes and issues are dropped while reset is held; gating here also
    // turns off bypass so every read port reports zero during reset.
    assign we_live  = WE3 && !rst;
    assign wr_en    = we_live && (A3 != ZERO_ADDR);
    assign iss_live = iss_valid && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[A3] <= WD3;
        end
    end

    assign RD1 = (A1 == ZERO_ADDR)               ? '0  :
                 (BYP && wr_en && (A3 == A1))    ? WD3 : mem[A1];
    assign RD2 = (A2 == ZERO_ADDR)               ? '0  :
                 (BYP && wr_en && (A3 == A2))    ? WD3 : mem[A2];
    assign a0  = (DBG_ADDR == ZERO_ADDR)         ? '0  :
                 (BYP && wr_en && (A3 == DBG_ADDR)) ? WD3 : mem[DBG_ADDR];

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BYPASS     (BYPASS)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .a1          (A1),
        .a2          (A2),
        .a3          (A3),
        .we3         (we_live),
        .iss_valid   (iss_live),
        .iss_rd      (iss_rd),
        .busy1       (busy1),
        .busy2       (busy2),
        .pending_cnt (pending_cnt)
    );

    assign stall = busy1 | busy2;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  A1 = '0, A2 = '0, A3 = '0, iss_rd = '0;
    logic        WE3 = 1'b0, iss_valid = 1'b0;
    logic [31:0] WD3 = '0;

    logic [31:0] rd1_b, rd2_b, a0_b, rd1_n, rd2_n, a0_n;
    logic        b1_b, b2_b, st_b, b1_n, b2_n, st_n;
    logic [5:0]  cnt_b, cnt_n;

    always #5 clk = ~clk;

    regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .BYPASS(1), .DBG_REG(10)) dut (
        .clk(clk), .rst(rst), .A1(A1), .A2(A2), .A3(A3), .WE3(WE3), .WD3(WD3),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .RD1(rd1_b), .RD2(rd2_b),
        .busy1(b1_b), .busy2(b2_b), .stall(st_b), .pending_cnt(cnt_b), .a0(a0_b));

    regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .BYPASS(0), .DBG_REG(10)) dut_nb (
        .clk(clk), .rst(rst), .A1(A1), .A2(A2), .A3(A3), .WE3(WE3), .WD3(WD3),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .RD1(rd1_n), .RD2(rd2_n),
        .busy1(b1_n), .busy2(b2_n), .stall(st_n), .pending_cnt(cnt_n), .a0(a0_n));

    typedef struct {
        logic [31:0] rd1, rd2, a0, rd1n, rd2n, a0n;
        logic        b1, b2, st, b1n, b2n, stn;
        logic [5:0]  cnt;
    } exp_t;

    exp_t        expq[$];
    int          checks = 0;
    int          errors = 0;

    // Architectural model: register contents and the set of registers with
    // an outstanding producer.
    logic [31:0] m_reg  [32];
    bit          m_busy [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input int a, input bit byp);
        if (rst || a == 0) return 32'd0;
        if (byp && WE3 && A3 == a) return WD3;
        return m_reg[a];
    endfunction

    function automatic bit m_busy_rd(input int a, input bit byp);
        if (rst || a == 0) return 1'b0;
        if (byp && WE3 && A3 == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [5:0] m_pending();
        int n = 0;
        for (int r = 0; r < 32; r++) if (m_busy[r]) n++;
        return 6'(n);
    endfunction

    task automatic drive(input bit r, input int a1, input int a2, input int a3,
                         input bit we, input logic [31:0] wd, input bit iv, input int ird);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; A1 = 5'(a1); A2 = 5'(a2); A3 = 5'(a3); WE3 = we; WD3 = wd;
        iss_valid = iv; iss_rd = 5'(ird);
        e.rd1  = m_read(a1, 1'b1); e.rd2  = m_read(a2, 1'b1); e.a0  = m_read(10, 1'b1);
        e.rd1n = m_read(a1, 1'b0); e.rd2n = m_read(a2, 1'b0); e.a0n = m_read(10, 1'b0);
        e.b1   = m_busy_rd(a1, 1'b1); e.b2  = m_busy_rd(a2, 1'b1); e.st  = e.b1 | e.b2;
        e.b1n  = m_busy_rd(a1, 1'b0); e.b2n = m_busy_rd(a2, 1'b0); e.stn = e.b1n | e.b2n;
        e.cnt  = rst ? 6'd0 : m_pending();
        expq.push_back(e);
        // State seen after the next rising edge (or immediately, for reset).
        if (r) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i]  = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (we && a3 != 0) m_reg[a3] = wd;
            if (we && a3 != 0 && !(iv && ird == a3)) m_busy[a3] = 1'b0;
            if (iv && ird != 0) m_busy[ird] = 1'b1;
        end
    endtask

    task automatic idle(input int a1, input int a2);
        drive(1'b0, a1, a2, 0, 1'b0, 32'd0, 1'b0, 0);
    endtask

    // Monitor: every cycle with a pending expectation is checked mid-cycle.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("rd1_byp",  rd1_b, e.rd1);
            chk("rd2_byp",  rd2_b, e.rd2);
            chk("a0_byp",   a0_b,  e.a0);
            chk("busy1_byp", 32'(b1_b), 32'(e.b1));
            chk("busy2_byp", 32'(b2_b), 32'(e.b2));
            chk("stall_byp", 32'(st_b), 32'(e.st));
            chk("cnt_byp",  32'(cnt_b), 32'(e.cnt));
            chk("rd1_nb",   rd1_n, e.rd1n);
            chk("rd2_nb",   rd2_n, e.rd2n);
            chk("a0_nb",    a0_n,  e.a0n);
            chk("busy1_nb", 32'(b1_n), 32'(e.b1n));
            chk("busy2_nb", 32'(b2_n), 32'(e.b2n));
            chk("stall_nb", 32'(st_n), 32'(e.stn));
            chk("cnt_nb",   32'(cnt_n), 32'(e.cnt));
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end

        // Reset, release, x0 write is discarded
        drive(1'b1, 10, 0, 0, 1'b0, 32'd0, 1'b0, 0);
        drive(1'b1, 10, 0, 0, 1'b0, 32'd0, 1'b0, 0);
        idle(10, 0);
        drive(1'b0, 0, 0, 0, 1'b1, 32'hDEADBEEF, 1'b0, 0);
        idle(0, 0);

        // Issue x5, then retire it with bypass visible in the same cycle
        drive(1'b0, 0, 0, 0, 1'b0, 32'd0, 1'b1, 5);
        idle(5, 0);
        drive(1'b0, 5, 0, 5, 1'b1, 32'h1234, 1'b0, 0);
        idle(5, 5);

        // Issue and retire x7 in the same cycle: busy stays set
        drive(1'b0, 0, 0, 0, 1'b0, 32'd0, 1'b1, 7);
        drive(1'b0, 7, 0, 7, 1'b1, 32'h55, 1'b1, 7);
        idle(7, 0);

        // Issue x3 while retiring busy x9, WAW on x3, retire of idle x4
        drive(1'b0, 0, 0, 0, 1'b0, 32'd0, 1'b1, 9);
        drive(1'b0, 9, 3, 9, 1'b1, 32'h99, 1'b1, 3);
        drive(1'b0, 3, 9, 0, 1'b0, 32'd0, 1'b1, 3);
        drive(1'b0, 3, 4, 4, 1'b1, 32'h44, 1'b0, 0);
        idle(3, 4);

        // Fill x1..x4 then assert reset between edges
        for (int r = 1; r <= 4; r++) drive(1'b0, 0, 0, 0, 1'b0, 32'd0, 1'b1, r);
        idle(1, 4);
        drive(1'b1, 1, 4, 0, 1'b0, 32'd0, 1'b0, 0);
        drive(1'b0, 0, 10, 10, 1'b1, 32'h2A, 1'b0, 0);
        idle(10, 1);

        // Randomised traffic, including occasional reset and address aliasing
        for (int n = 0; n < 400; n++) begin
            int a1, a2, a3, ird;
            bit we, iv, r;
            a3  = int'($urandom_range(0, 31));
            ird = int'($urandom_range(0, 31));
            a1  = ($urandom_range(0, 3) == 0) ? a3 : int'($urandom_range(0, 31));
            a2  = ($urandom_range(0, 3) == 0) ? ird : int'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) a3 = 10;
            we  = ($urandom_range(0, 1) == 1);
            iv  = ($urandom_range(0, 2) != 0);
            r   = ($urandom_range(0, 99) == 0);
            drive(r, a1, a2, a3, we, $urandom, iv, ird);
        end
        idle(0, 0);

        repeat (2) @(negedge clk);
        #1;
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
